// File: rtl/ram_march_ctrl_if.sv
`default_nettype none
// ram_march_ctrl_if: control/status and RAM-side bundle for the march self-test sequencer.
// Revision: 1.0

interface ram_march_ctrl_if #(
  parameter int AW = 6,
  parameter int DW = 8
);
  logic          start;
  logic [DW-1:0] seed;
  logic [DW-1:0] ram_ip;
  logic [AW-1:0] ram_add;
  logic          ram_wr;
  logic [DW-1:0] ram_q;
  logic          busy;
  logic          done;
  logic          pass;
  logic [7:0]    err_cnt;
  logic [AW-1:0] err_add;
  logic [DW-1:0] err_exp;
  logic [DW-1:0] err_act;

  modport master (
    input  start, seed, ram_q,
    output ram_ip, ram_add, ram_wr, busy, done, pass,
           err_cnt, err_add, err_exp, err_act
  );

  modport slave (
    output start, seed, ram_q,
    input  ram_ip, ram_add, ram_wr, busy, done, pass,
           err_cnt, err_add, err_exp, err_act
  );
endinterface

`default_nettype wire

// File: rtl/ram_march_ctrl.sv
`default_nettype none
// ram_march_ctrl: two-pass (true/inverted) write/read-compare self-test for a single-port RAM.
// Revision: 1.0

module ram_march_ctrl #(
  parameter int AW     = 6,
  parameter int DW     = 8,
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  ram_march_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_W0   = 3'd1,
    S_R0   = 3'd2,
    S_D0   = 3'd3,
    S_W1   = 3'd4,
    S_R1   = 3'd5,
    S_D1   = 3'd6,
    S_DONE = 3'd7
  } state_t;

  localparam logic [AW-1:0]   c_LAST  = AW'(DEPTH - 1);
  localparam int              c_CW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [c_CW-1:0] c_DLAST = c_CW'(RD_LAT - 1);

  state_t          r_state;
  logic [DW-1:0]   r_seed;
  logic [DW-1:0]   r_ram_ip;
  logic [AW-1:0]   r_ram_add;
  logic            r_ram_wr;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic [7:0]      r_err_cnt;
  logic [AW-1:0]   r_err_add;
  logic [DW-1:0]   r_err_exp;
  logic [DW-1:0]   r_err_act;
  logic [c_CW-1:0] r_dcnt;
  logic [RD_LAT-1:0] r_pv;
  logic [DW-1:0]   r_pexp [RD_LAT];
  logic [AW-1:0]   r_padd [RD_LAT];

  logic [AW-1:0]   w_add_nxt;
  logic            w_at_last;
  logic            w_rd;
  logic [DW-1:0]   w_rd_sum;
  logic [DW-1:0]   w_rd_exp;
  logic [DW-1:0]   w_wr_sum;
  logic            w_mis;

  assign w_add_nxt = r_ram_add + AW'(1);
  assign w_at_last = (r_ram_add == c_LAST);
  assign w_rd      = (r_state == S_R0) || (r_state == S_R1);
  assign w_rd_sum  = r_seed + DW'(r_ram_add);
  assign w_rd_exp  = (r_state == S_R1) ? ~w_rd_sum : w_rd_sum;
  assign w_wr_sum  = r_seed + DW'(w_add_nxt);
  // The oldest pipeline stage lines up with the RAM data of the read it describes.
  assign w_mis     = r_pv[RD_LAT-1] && (bus.ram_q != r_pexp[RD_LAT-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_seed    <= '0;
      r_ram_ip  <= '0;
      r_ram_add <= '0;
      r_ram_wr  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err_cnt <= '0;
      r_err_add <= '0;
      r_err_exp <= '0;
      r_err_act <= '0;
      r_dcnt    <= '0;
      r_pv      <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_pexp[i] <= '0;
        r_padd[i] <= '0;
      end
    end else begin
      r_done    <= 1'b0;
      r_pv[0]   <= w_rd;
      r_pexp[0] <= w_rd_exp;
      r_padd[0] <= r_ram_add;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i]   <= r_pv[i-1];
        r_pexp[i] <= r_pexp[i-1];
        r_padd[i] <= r_padd[i-1];
      end

      if (w_mis) begin
        if (r_err_cnt != 8'hFF) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
        if (r_err_cnt == 8'd0) begin
          r_err_add <= r_padd[RD_LAT-1];
          r_err_exp <= r_pexp[RD_LAT-1];
          r_err_act <= bus.ram_q;
        end
      end

      unique case (r_state)
        S_IDLE: begin
          r_ram_wr <= 1'b0;
          r_ram_ip <= '0;
          if (bus.start) begin
            r_seed    <= bus.seed;
            r_pass    <= 1'b0;
            r_err_cnt <= '0;
            r_err_add <= '0;
            r_err_exp <= '0;
            r_err_act <= '0;
            r_busy    <= 1'b1;
            r_ram_wr  <= 1'b1;
            r_ram_add <= '0;
            r_ram_ip  <= bus.seed;
            r_state   <= S_W0;
          end
        end
        S_W0, S_W1: begin
          if (w_at_last) begin
            r_ram_wr  <= 1'b0;
            r_ram_ip  <= '0;
            r_ram_add <= '0;
            r_state   <= (r_state == S_W0) ? S_R0 : S_R1;
          end else begin
            r_ram_add <= w_add_nxt;
            r_ram_ip  <= (r_state == S_W0) ? w_wr_sum : ~w_wr_sum;
          end
        end
        S_R0, S_R1: begin
          if (w_at_last) begin
            r_dcnt  <= '0;
            r_state <= (r_state == S_R0) ? S_D0 : S_D1;
          end else begin
            r_ram_add <= w_add_nxt;
          end
        end
        S_D0: begin
          if (r_dcnt == c_DLAST) begin
            r_ram_wr  <= 1'b1;
            r_ram_add <= '0;
            r_ram_ip  <= ~r_seed;
            r_state   <= S_W1;
          end else begin
            r_dcnt <= r_dcnt + c_CW'(1);
          end
        end
        S_D1: begin
          if (r_dcnt == c_DLAST) begin
            // Fold in the verdict of the final compare landing on this same edge.
            r_pass  <= (r_err_cnt == 8'd0) && !w_mis;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_dcnt <= r_dcnt + c_CW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ram_ip  = r_ram_ip;
  assign bus.ram_add = r_ram_add;
  assign bus.ram_wr  = r_ram_wr;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.pass    = r_pass;
  assign bus.err_cnt = r_err_cnt;
  assign bus.err_add = r_err_add;
  assign bus.err_exp = r_err_exp;
  assign bus.err_act = r_err_act;

endmodule

`default_nettype wire
